// File: rtl/input_cond_pkg.sv
// Shared widths, channel counts and counter sizing for the board input
// conditioning front end.
package input_cond_pkg;

    localparam int unsigned SW_BD_W = 5;
    localparam int unsigned ACT_W   = 4;
    localparam int unsigned N_SW    = 6;
    localparam int unsigned N_BT    = 6;

    // Counter must hold values up to DB_CYCLES-1; sized on DB_CYCLES+1 so DB_CYCLES==1 still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioned input: 2-FF synchroniser, consecutive-mismatch debounce
// counter, and an optional registered press pulse for button channels.
module debounce_ch
    import input_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter bit          IS_BUTTON = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out
);

    localparam int unsigned           CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             q;
    logic             pulse;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // The pulse is registered on the same edge q rises, so it aligns with the accepted press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            q     <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (s2 == q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                q     <= s2;
                cnt   <= '0;
                pulse <= s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out = IS_BUTTON ? pulse : q;

endmodule

// File: rtl/input_cond.sv
// Board input front end: debounced switch levels and one-cycle button press
// pulses for topControl.
module input_cond
    import input_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SW_BD_W-1:0] bd_num_sw_in,
    input  logic               st_sw_in,
    input  logic               rst_bt_in,
    input  logic               rand_bt_in,
    input  logic [ACT_W-1:0]   act_bt_in,
    output logic [SW_BD_W-1:0] bd_num_sw,
    output logic               st_sw,
    output logic               rst_bt,
    output logic               rand_bt,
    output logic [ACT_W-1:0]   act_bt
);

    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_out;
    logic [N_BT-1:0] bt_raw;
    logic [N_BT-1:0] bt_out;

    assign sw_raw = {st_sw_in, bd_num_sw_in};
    assign bt_raw = {rand_bt_in, rst_bt_in, act_bt_in};

    genvar g;
    generate
        for (g = 0; g < N_SW; g++) begin : g_sw
            debounce_ch #(
                .DB_CYCLES (DB_CYCLES),
                .IS_BUTTON (1'b0)
            ) u_ch (
                .clk (clk),
                .rst (rst),
                .raw (sw_raw[g]),
                .out (sw_out[g])
            );
        end
        for (g = 0; g < N_BT; g++) begin : g_bt
            debounce_ch #(
                .DB_CYCLES (DB_CYCLES),
                .IS_BUTTON (1'b1)
            ) u_ch (
                .clk (clk),
                .rst (rst),
                .raw (bt_raw[g]),
                .out (bt_out[g])
            );
        end
    endgenerate

    assign bd_num_sw = sw_out[SW_BD_W-1:0];
    assign st_sw     = sw_out[N_SW-1];
    assign act_bt    = bt_out[ACT_W-1:0];
    assign rst_bt    = bt_out[ACT_W];
    assign rand_bt   = bt_out[ACT_W+1];

endmodule
